// File: rtl/cplx_bin_accumulator.sv
// -----------------------------------------------------------------------------
// cplx_bin_accumulator
//
// Multi-channel complex "bin" accumulator. Each channel (bin) sums ACC_LEN
// complex samples. The sample that completes a block is folded into the sum
// and the total is dumped into a single output holding register, which uses a
// valid/ready handshake. The channel then restarts from zero.
//
// Optional feature (compile-time macro):
//   ACC_SATURATE_EN  defined   -> each dumped component saturates to the
//                                 signed DATA_W range
//                    undefined -> each dumped component is the low DATA_W bits
//                                 of the sum (wraps)
//
// Parameters:
//   DATA_W   signed width of each real/imag component
//   GUARD_W  extra accumulator bits (ACC_W = DATA_W + GUARD_W)
//   NUM_CH   number of independent channels
//   ACC_LEN  samples per dump, 1..2**GUARD_W
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   clr        synchronous clear of all sums, counters and pending output
//   in_valid   input sample present
//   in_ready   block accepts a sample this cycle (combinational)
//   in_ch      channel index of the sample (ignored if >= NUM_CH)
//   in_data    {real, imag}, DATA_W each, two's complement
//   out_valid  dumped result held
//   out_ready  consumer takes the result
//   out_ch     channel of the dumped result
//   out_data   {real, imag} of the dumped sum, DATA_W each
// -----------------------------------------------------------------------------
module cplx_bin_accumulator #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 3,
  parameter int NUM_CH  = 4,
  parameter int ACC_LEN = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [2*DATA_W-1:0] out_data
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(GUARD_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(GUARD_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  // Reduce a full-width sum to an output component.
  function automatic logic signed [DATA_W-1:0] fit_out(input logic signed [ACC_W-1:0] s);
`ifdef ACC_SATURATE_EN
    if (s > SAT_MAX)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < SAT_MIN)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  // Per-channel state
  logic signed [ACC_W-1:0] r_sum_re [NUM_CH];
  logic signed [ACC_W-1:0] r_sum_im [NUM_CH];
  logic [CNT_W-1:0]        r_cnt    [NUM_CH];

  // Output holding register
  logic                r_out_valid;
  logic [CH_W-1:0]     r_out_ch;
  logic [2*DATA_W-1:0] r_out_data;

  logic signed [DATA_W-1:0] w_in_re;
  logic signed [DATA_W-1:0] w_in_im;
  logic signed [ACC_W-1:0]  w_ext_re;
  logic signed [ACC_W-1:0]  w_ext_im;
  logic signed [ACC_W-1:0]  w_new_re;
  logic signed [ACC_W-1:0]  w_new_im;
  logic                     w_ch_ok;
  logic                     w_accept;
  logic                     w_last;
  logic [CH_W-1:0]          w_idx;

  // A channel index field wider than NUM_CH needs a range check; when the
  // field exactly covers NUM_CH every index is legal.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_chk
      assign w_ch_ok = (int'(in_ch) < NUM_CH);
    end
  endgenerate

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Keep array reads in range even for an illegal channel (result unused then).
  assign w_idx = w_ch_ok ? in_ch : '0;

  assign w_in_re  = in_data[2*DATA_W-1:DATA_W];
  assign w_in_im  = in_data[DATA_W-1:0];
  assign w_ext_re = {{GUARD_W{w_in_re[DATA_W-1]}}, w_in_re};
  assign w_ext_im = {{GUARD_W{w_in_im[DATA_W-1]}}, w_in_im};

  // Sums wrap modulo 2**ACC_W by construction.
  assign w_new_re = r_sum_re[w_idx] + w_ext_re;
  assign w_new_im = r_sum_im[w_idx] + w_ext_im;
  assign w_last   = (r_cnt[w_idx] == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sum_re[i] <= '0;
        r_sum_im[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_out_valid <= 1'b0;
      if (!reset) begin
        r_out_ch   <= '0;
        r_out_data <= '0;
      end
    end else begin
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;
      // A dump can only occur while the holding register is empty or being
      // drained, so a new result safely overrides the clear above.
      if (w_accept && w_ch_ok) begin
        if (w_last) begin
          r_sum_re[w_idx] <= '0;
          r_sum_im[w_idx] <= '0;
          r_cnt[w_idx]    <= '0;
          r_out_valid     <= 1'b1;
          r_out_ch        <= in_ch;
          r_out_data      <= {fit_out(w_new_re), fit_out(w_new_im)};
        end else begin
          r_sum_re[w_idx] <= w_new_re;
          r_sum_im[w_idx] <= w_new_im;
          r_cnt[w_idx]    <= r_cnt[w_idx] + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_cplx_bin_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cplx_bin_accumulator
//
// Self-checking bench for cplx_bin_accumulator at default parameters.
// Expected dumps are queued when the completing sample is driven; a negedge
// monitor records every handshaked output, and each test pops and compares.
// Honors ACC_SATURATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cplx_bin_accumulator;

  localparam int DATA_W  = 16;
  localparam int GUARD_W = 3;
  localparam int NUM_CH  = 4;
  localparam int ACC_LEN = 8;
  localparam int CH_W    = 2;

  typedef logic [CH_W+2*DATA_W-1:0] res_t;

  logic                clk;
  logic                reset;
  logic                clr;
  logic                in_valid;
  logic                in_ready;
  logic [CH_W-1:0]     in_ch;
  logic [2*DATA_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [CH_W-1:0]     out_ch;
  logic [2*DATA_W-1:0] out_data;

  res_t exp_q[$];
  res_t cap_q[$];
  int   checks = 0;
  int   errors = 0;

  cplx_bin_accumulator #(
    .DATA_W (DATA_W),
    .GUARD_W(GUARD_W),
    .NUM_CH (NUM_CH),
    .ACC_LEN(ACC_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each result that completes a handshake at the following edge.
  always @(negedge clk)
    if (reset && out_valid && out_ready)
      cap_q.push_back({out_ch, out_data});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample and hold it until accepted (bounded).
  task automatic send(input int ch, input int re, input int im);
    int guard = 0;
    in_valid = 1'b1;
    in_ch    = ch[CH_W-1:0];
    in_data  = {re[15:0], im[15:0]};
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cap(input int n, output bit ok);
    int guard = 0;
    while (cap_q.size() < n && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #1;
    ok = (cap_q.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if ({out_ch, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_out_regs: got ch=%h data=%h, required 0/0", out_ch, out_data);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    res_t e, a;
    bit ok;
    for (int i = 0; i < 8; i++) send(0, 100, -100);
    exp_q.push_back({2'd0, 32'h0320_FCE0});
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'h0320_FCE0) begin
      errors++;
      $display("FAIL basic_latency: got v=%b ch=%h data=%h, required 1/0/0320fce0", out_valid, out_ch, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: out_valid got %b, required 0", out_valid);
    end
    wait_cap(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: captured %0d, required 1", cap_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL basic_result: got %h, required %h", a, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_saturate();
    res_t e, a;
    bit ok;
    for (int i = 0; i < 8; i++) send(1, 32767, -32768);
`ifdef ACC_SATURATE_EN
    exp_q.push_back({2'd1, 32'h7FFF_8000});
`else
    exp_q.push_back({2'd1, 32'hFFF8_0000});
`endif
    wait_cap(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sat_timeout: captured %0d, required 1", cap_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sat_result: got %h, required %h", a, e);
      end
    end
    exp_q.delete();
  endtask

  // Final samples of all four channels land on consecutive cycles, so each
  // dump replaces the previous one while it is being drained.
  task automatic test_back_to_back();
    res_t e, a;
    bit ok;
    int ch, v;
    for (int s = 0; s < 32; s++) begin
      ch = s % 4;
      send(ch, ch + 1, ch + 1);
      if (s >= 28) begin
        v = 8 * (ch + 1);
        exp_q.push_back({ch[CH_W-1:0], v[15:0], v[15:0]});
      end
    end
    wait_cap(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_timeout: captured %0d, required 4", cap_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rr_result: got %h, required %h", a, e);
      end
    end
    repeat (3) tick();
    checks++;
    if (cap_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_extra: extra=%0d out_valid=%b, required 0/0", cap_q.size(), out_valid);
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic test_backpressure();
    res_t e, a;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3, 5, -5);
    exp_q.push_back({2'd3, 32'h0028_FFD8});
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = {16'd9, 16'd9};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0028_FFD8) begin
        errors++;
        $display("FAIL hold_stall: got rdy=%b v=%b data=%h, required 0/1/0028ffd8", in_ready, out_valid, out_data);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_drain_ready: got %b, required 1", in_ready);
    end
    wait_cap(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_timeout: captured %0d, required 1", cap_q.size());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_drained: out_valid got %b, required 0", out_valid);
    end
    // Stalled samples must not have been absorbed into channel 3.
    for (int i = 0; i < 8; i++) send(3, 1, 1);
    exp_q.push_back({2'd3, 32'h0008_0008});
    wait_cap(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_timeout2: captured %0d, required 2", cap_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL hold_result: got %h, required %h", a, e);
      end
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic test_clear();
    res_t e, a;
    bit ok;
    for (int i = 0; i < 5; i++) send(2, 7, 7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_out_valid: got %b, required 0", out_valid);
    end
    for (int i = 0; i < 8; i++) send(2, 1, 1);
    exp_q.push_back({2'd2, 32'h0008_0008});
    wait_cap(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clr_timeout: captured %0d, required 1", cap_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL clr_result: got %h, required %h", a, e);
      end
    end
    repeat (3) tick();
    checks++;
    if (cap_q.size() != 0) begin
      errors++;
      $display("FAIL clr_residue: extra outputs %0d, required 0", cap_q.size());
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic test_reset_mid();
    res_t e, a;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 9, 9);
    for (int i = 0; i < 8; i++) send(1, 1, 1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: out_valid got %b, required 1", out_valid);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_out_valid: got %b, required 0", out_valid);
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(0, 2, 3);
    exp_q.push_back({2'd0, 32'h0010_0018});
    wait_cap(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_timeout: captured %0d, required 1", cap_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rstmid_result: got %h, required %h", a, e);
      end
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  initial begin
    reset     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cplx_bin_accumulator.md
CPLX_BIN_ACCUMULATOR -- requirements
Module: cplx_bin_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed width of each real/imag component.
REQ-002 SHALL have parameter GUARD_W, default 3: extra accumulator bits; accumulator width ACC_W = DATA_W+GUARD_W.
REQ-003 SHALL have parameter NUM_CH, default 4: independent accumulation channels (bins); CH_W = max(1,clog2(NUM_CH)).
REQ-004 SHALL have parameter ACC_LEN, default 8: samples summed per channel before dump; legal range 1..2^GUARD_W.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port clr  input  1  synchronous clear of all channel sums and counters.
REQ-008 SHALL have port in_valid  input  1  input sample present.
REQ-009 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port in_ch  input  CH_W  channel index of the sample.
REQ-011 SHALL have port in_data  input  2*DATA_W  {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}, two's complement.
REQ-012 SHALL have port out_valid  output  1  dumped result held.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port out_ch  output  CH_W  channel of dumped result.
REQ-015 SHALL have port out_data  output  2*DATA_W  {real, imag} of dumped sum, DATA_W each.

Function
REQ-016 SHALL hold per channel a signed ACC_W real sum, signed ACC_W imag sum and a sample counter 0..ACC_LEN-1.
REQ-017 SHALL accept a sample when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-018 SHALL, on accept with count<ACC_LEN-1, add sign-extended components to channel in_ch sums and increment its counter.
REQ-019 SHALL, on accept with count==ACC_LEN-1, load output register with sum+sample, set out_valid next cycle, zero that channel's sums and counter.
REQ-020 SHALL latch result 1 cycle after the final accepted sample; out_valid, out_ch, out_data stable until out_valid && out_ready.
REQ-021 SHALL clear out_valid on out_valid && out_ready unless a new dump is loaded the same cycle, in which case new result replaces old with out_valid staying 1.
REQ-022 SHALL wrap accumulator sums modulo 2^ACC_W (no internal saturation).
REQ-023 SHALL ignore samples with in_ch >= NUM_CH (accepted, no state change).
REQ-024 SHALL, on clr, zero all sums and counters and drop out_valid; clr has priority over a simultaneous sample or dump, which is discarded.
REQ-025 SHALL keep channels independent: interleaved in_ch values never affect other channels' sums or counters.

Reset
REQ-026 SHALL, while reset==0 at a clk edge, zero all sums, counters, out_ch, out_data and out_valid; in_ready reads 1 the cycle after reset release.
REQ-027 SHALL discard any partial accumulation and pending output when reset asserts mid-operation.

Configuration
REQ-028 SHALL use macro ACC_SATURATE_EN: defined -> each output component saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; undefined -> output component is sum[DATA_W-1:0] (truncation, wrap).

Verification (defaults DATA_W=16, GUARD_W=3, NUM_CH=4, ACC_LEN=8)
REQ-029 SHALL test: 8 samples ch0 {100,-100}, out_ready=1 -> one out_valid pulse 1 cycle after 8th, out_ch=0, out_data=0x0320_FCE0.
REQ-030 SHALL test: 8 samples ch1 real 0x7FFF imag 0x8000 -> with ACC_SATURATE_EN out_data=0x7FFF_8000; without -> 0xFFF8_0000.
REQ-031 SHALL test: ch0..ch3 round-robin, value ch+1 both parts, 32 samples -> four dumps in order ch0..ch3, real=imag=8*(ch+1).
REQ-032 SHALL test: out_ready=0 with result held, further samples -> in_ready=0, out_data stable; out_ready=1 -> output drains, in_ready=1.
REQ-033 SHALL test: clr after 5 samples ch2, then 8 samples {1,1} -> single dump 0x0008_0008, no residue.
REQ-034 SHALL test: reset low during accumulation -> out_valid=0, next 8 samples {2,3} dump 0x0010_0018.
